// File: rtl/uart_axis_rr_arbiter.sv
// Round-robin merge of N_CH UART word-packer AXI-Stream sources onto one
// AXI-Stream master. Each grant allows at most BURST_LEN beats from one
// channel. TUSER carries the source channel of every output beat.
module uart_axis_rr_arbiter #(
  parameter int N_CH      = 4,
  parameter int ID_W      = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                 M_AXIS_ACLK,
  input  logic                 M_AXIS_ARESETN,
  input  logic [N_CH-1:0]      cfg_en,
  input  logic [N_CH-1:0]      S_AXIS_TVALID,
  input  logic [N_CH*32-1:0]   S_AXIS_TDATA,
  output logic [N_CH-1:0]      S_AXIS_TREADY,
  output logic                 M_AXIS_TVALID,
  output logic [31:0]          M_AXIS_TDATA,
  output logic [ID_W-1:0]      M_AXIS_TUSER,
  input  logic                 M_AXIS_TREADY,
  output logic [15:0]          grant_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Reset value of last_grant makes channel 0 the first winner.
  localparam logic [ID_W-1:0] LAST_CH     = ID_W'(N_CH - 1);
  localparam logic [7:0]      BURST_LEN_C = 8'(BURST_LEN);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ID_W-1:0]   grant_r;
  logic [ID_W-1:0]   grant_nxt_s;
  logic [ID_W-1:0]   last_grant_r;
  logic [ID_W-1:0]   last_grant_nxt_s;
  logic [7:0]        beat_cnt_r;
  logic [7:0]        beat_cnt_nxt_s;
  logic [15:0]       grant_cnt_r;
  logic              grant_inc_s;

  logic [N_CH-1:0]   req_s;
  logic [N_CH-1:0]   req_rot_s;
  int                off_s;
  logic [ID_W-1:0]   pick_s;
  logic              pick_vld_s;

  logic [N_CH-1:0]   grant_oh_s;
  logic              g_en_s;
  logic [31:0]       sel_data_s;
  logic              can_load_s;
  logic [N_CH-1:0]   tready_s;
  logic              xfer_s;

  logic              m_tvalid_r;
  logic [31:0]       m_tdata_r;
  logic [ID_W-1:0]   m_tuser_r;

  // Round-robin pick: rotate requests so bit 0 is the channel after last_grant, take the lowest set bit.
  always_comb begin
    req_s      = S_AXIS_TVALID & cfg_en;
    req_rot_s  = N_CH'({req_s, req_s} >> (int'(last_grant_r) + 1));
    pick_vld_s = |req_s;
    off_s      = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      off_s = req_rot_s[i] ? i : off_s;
    end
    pick_s = ID_W'((int'(last_grant_r) + 1 + off_s) % N_CH);
  end

  // Granted-channel decode: one-hot grant, its enable bit and its data word.
  always_comb begin
    grant_oh_s = {{(N_CH-1){1'b0}}, 1'b1} << grant_r;
    g_en_s     = |(cfg_en & grant_oh_s);
    sel_data_s = 32'h0000_0000;
    for (int k = 0; k < N_CH; k++) begin
      sel_data_s = sel_data_s | (S_AXIS_TDATA[32*k +: 32] & {32{grant_oh_s[k]}});
    end
  end

  // FSM state register: arbitration state, grant bookkeeping and grant counter.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_r      <= ST_IDLE;
      grant_r      <= {ID_W{1'b0}};
      last_grant_r <= LAST_CH;
      beat_cnt_r   <= 8'd0;
      grant_cnt_r  <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      grant_cnt_r  <= grant_inc_s ? (grant_cnt_r + 16'd1) : grant_cnt_r;
    end
  end

  // FSM next state: grant in IDLE, count beats and decide when to release in BURST.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    grant_inc_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s    = ST_BURST;
          grant_nxt_s    = pick_s;
          beat_cnt_nxt_s = 8'd0;
          grant_inc_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!g_en_s) begin
          // Channel disabled under us: give the grant up right away.
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = grant_r;
        end else if (!can_load_s) begin
          // Downstream stall freezes the burst.
          state_nxt_s = ST_BURST;
        end else if (xfer_s) begin
          if ((beat_cnt_r + 8'd1) == BURST_LEN_C) begin
            state_nxt_s      = ST_IDLE;
            last_grant_nxt_s = grant_r;
            beat_cnt_nxt_s   = 8'd0;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 8'd1;
          end
        end else begin
          // Room downstream but the source has nothing: release early.
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = grant_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: source ready for the granted channel and the resulting handshake.
  always_comb begin
    can_load_s = !m_tvalid_r || M_AXIS_TREADY;
    if ((state_r == ST_BURST) && can_load_s) begin
      tready_s = grant_oh_s & cfg_en;
    end else begin
      tready_s = {N_CH{1'b0}};
    end
    xfer_s = |(S_AXIS_TVALID & tready_s);
  end

  // Single-stage output register: load on transfer, drop valid when consumed, otherwise hold.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= 32'h0000_0000;
      m_tuser_r  <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      m_tvalid_r <= 1'b1;
      m_tdata_r  <= sel_data_s;
      m_tuser_r  <= grant_r;
    end else if (M_AXIS_TREADY) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  assign S_AXIS_TREADY = tready_s;
  assign M_AXIS_TVALID = m_tvalid_r;
  assign M_AXIS_TDATA  = m_tdata_r;
  assign M_AXIS_TUSER  = m_tuser_r;
  assign grant_cnt     = grant_cnt_r;

endmodule

// File: doc/uart_axis_rr_arbiter.md
Name: uart_axis_rr_arbiter

Overview:
- Merges N_CH independent 32-bit AXI-Stream word sources into a single AXI-Stream master. Each source is a UART-receive word packer.
- Round-robin arbitration with bounded bursts. The granted channel index is tagged on TUSER.
- Sits between the per-pin UART packers and the DMA/interconnect input, so all serial channels share one stream port.

Parameters:
- N_CH, 4, number of source channels (2..8).
- ID_W, 2, TUSER width; must satisfy 2**ID_W >= N_CH.
- BURST_LEN, 4, maximum beats accepted from one channel per grant (1..255).

Ports:
- M_AXIS_ACLK  input  1  clock.
- M_AXIS_ARESETN  input  1  reset; asynchronous, active-low.
- cfg_en  input  N_CH  per-channel enable mask; a disabled channel is never granted.
- S_AXIS_TVALID  input  N_CH  per-channel valid.
- S_AXIS_TDATA  input  N_CH*32  channel k occupies bits [32k+31:32k].
- S_AXIS_TREADY  output  N_CH  per-channel ready; at most one bit high.
- M_AXIS_TVALID  output  1  registered output valid.
- M_AXIS_TDATA  output  32  registered output data.
- M_AXIS_TUSER  output  ID_W  source channel index of the current beat.
- M_AXIS_TREADY  input  1  downstream ready.
- grant_cnt  output  16  total grants issued; wraps at 65535 -> 0.

Behaviour:
- Reset: async assert, sync deassert on M_AXIS_ACLK.
  - State=IDLE, grant=0, last_grant=N_CH-1 (so channel 0 wins first), beat_cnt=0.
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TUSER=0, S_AXIS_TREADY=0, grant_cnt=0.
  - Reset mid-burst discards the in-flight beat; no partial output after release.
- Output register: single stage.
  - can_load = !M_AXIS_TVALID || M_AXIS_TREADY.
  - The output holds TDATA/TUSER stable while TVALID=1 and TREADY=0 (AXIS rule).
- S_AXIS_TREADY[k] = (state==BURST) && (grant==k) && cfg_en[k] && can_load. This is combinational from M_AXIS_TREADY by design.
- State IDLE:
  - req = S_AXIS_TVALID & cfg_en.
  - If req!=0: grant = first set bit of req scanning last_grant+1, last_grant+2, ... with wrap modulo N_CH. Then beat_cnt=0, grant_cnt++, go to BURST.
  - If req==0: stay in IDLE.
  - If an output beat is pending, TVALID stays asserted and drains independently.
- State BURST (channel g granted):
  - Transfer: S_AXIS_TVALID[g] && S_AXIS_TREADY[g]. On transfer, the next cycle has M_AXIS_TVALID=1, TDATA=channel g data, TUSER=g, and beat_cnt increments.
  - If the transfer makes beat_cnt==BURST_LEN: go to IDLE, last_grant=g.
  - If can_load && !S_AXIS_TVALID[g]: release with no transfer; go to IDLE, last_grant=g.
  - If cfg_en[g] drops: release next cycle; no further beats are accepted from g.
  - If !can_load (downstream stall): hold in BURST; neither beat_cnt nor the release condition is evaluated.
- If M_AXIS_TVALID is consumed with no new transfer that cycle, M_AXIS_TVALID falls to 0 in the next cycle.
- Latency:
  - Source valid seen in IDLE at cycle t -> grant and TREADY at t+1 -> M_AXIS_TVALID at t+2.
  - Within a burst: one beat per cycle; transfer at t -> output at t+1.
- Arbitration bubble: one IDLE cycle between consecutive grants, including re-grant of the same channel.
- Fairness:
  - A channel with continuous valid receives at most BURST_LEN beats before every other requesting enabled channel gets a grant.
  - Worst-case wait for a requester is (N_CH-1)*(BURST_LEN+1) accepted-beat cycles under no backpressure.
- Simultaneous events: a channel's valid that rises in the same cycle the grant leaves it competes in the next IDLE evaluation, in round-robin order.
- Data is never dropped or duplicated; a beat leaves the source only on its handshake.

Test Plan:
- Only ch2 valid, data 0xA5A5_0002, M_AXIS_TREADY=1 -> one output beat TDATA=0xA5A5_0002, TUSER=2, TVALID high exactly 1 cycle, t+2 after source valid; grant_cnt=1.
- ch0..ch3 continuously valid with 8 words each, BURST_LEN=4, TREADY=1 -> TUSER order 0,0,0,0,1,1,1,1,2×4,3×4,0×4,... and each channel's data in source order; 32 beats total.
- ch1 valid, M_AXIS_TREADY held low 10 cycles after first beat -> TDATA/TUSER stable over those 10 cycles; S_AXIS_TREADY[1]=0 throughout; resumes with no loss when TREADY=1.
- cfg_en=4'b1011, ch2 continuously valid along with ch3 -> ch2 never granted; S_AXIS_TREADY[2]=0 always; only TUSER=3 beats appear.
- ch0 and ch1 valid; M_AXIS_ARESETN pulsed low mid-burst after 2 beats of ch0 -> all outputs at reset values; after release ch0 is granted first and grant_cnt restarts at 1.
- ch3 alone issues 1 word, idles 5 cycles, issues another -> two separate grants (grant_cnt=2); burst released after the first beat via the valid-low rule.
